// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Requester IDs are 3 bits wide so up to eight writeback sources fit.
package regfile_pkg;

    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int REQ_IDW = 3;

    typedef logic [REQ_IDW-1:0] req_id_t;

    localparam req_id_t REQ_ALU = 3'd0;
    localparam req_id_t REQ_LSU = 3'd1;
    localparam req_id_t REQ_MUL = 3'd2;

    // Successor of a requester ID, wrapping at n.
    function automatic req_id_t next_id(input req_id_t id, input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end
        return id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant for NUM_REQ requesters: the search starts at the pointer
// and the pointer moves just past the winner whenever a grant is issued.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output req_id_t            gnt_id_o,
    output logic               gnt_valid_o
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        int   idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_id_o    = req_id_t'(idx);
                gnt_valid_o = 1'b1;
            end
        end
    end

    // Any grant is a transfer, since a grant only goes to an asserted request.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = next_id(gnt_id_o, NUM_REQ);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter plus busy scoreboard in front of a single-write-port register file.
// Defining REGFILE_WB_BYPASS_EN adds operand bypass from the registered write port.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int NREG    = regfile_pkg::NREG,
    parameter int AW      = regfile_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      wb_valid,
    input  logic [NUM_REQ*AW-1:0]   wb_rd,
    input  logic [NUM_REQ*XLEN-1:0] wb_data,
    output logic [NUM_REQ-1:0]      wb_ready,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic [AW-1:0]           rs1,
    input  logic [AW-1:0]           rs2,
    output logic                    hazard,
    output logic                    reg_write,
    output logic [AW-1:0]           reg_rd,
    output logic [XLEN-1:0]         reg_wdata
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                    byp1_en,
    output logic                    byp2_en,
    output logic [XLEN-1:0]         byp1_data,
    output logic [XLEN-1:0]         byp2_data
`endif
);

    import regfile_pkg::*;

    req_id_t         gnt_id;
    logic            gnt_valid;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    logic            reg_write_q, reg_write_d;
    logic [AW-1:0]   reg_rd_q, reg_rd_d;
    logic [XLEN-1:0] reg_wdata_q, reg_wdata_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            haz1, haz2;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (wb_valid),
        .gnt_o      (wb_ready),
        .gnt_id_o   (gnt_id),
        .gnt_valid_o(gnt_valid)
    );

    always_comb begin
        win_rd   = wb_rd[int'(gnt_id)*AW +: AW];
        win_data = wb_data[int'(gnt_id)*XLEN +: XLEN];
    end

    // A granted write to x0 is consumed but never reaches the register file.
    always_comb begin
        reg_write_d = gnt_valid && (win_rd != '0);
        reg_rd_d    = reg_rd_q;
        reg_wdata_d = reg_wdata_q;
        if (reg_write_d) begin
            reg_rd_d    = win_rd;
            reg_wdata_d = win_data;
        end
    end

    assign issue_ready = !busy_q[issue_rd] || (issue_rd == '0);

    // Clear first, then set, so a same-cycle set on the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[reg_rd_q] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        byp1_en   = reg_write_q && (rs1 != '0) && (reg_rd_q == rs1);
        byp2_en   = reg_write_q && (rs2 != '0) && (reg_rd_q == rs2);
        byp1_data = byp1_en ? reg_wdata_q : '0;
        byp2_data = byp2_en ? reg_wdata_q : '0;
        haz1      = (rs1 != '0) && busy_q[rs1] && !byp1_en;
        haz2      = (rs2 != '0) && busy_q[rs2] && !byp2_en;
    end
`else
    always_comb begin
        haz1 = (rs1 != '0) && busy_q[rs1];
        haz2 = (rs2 != '0) && busy_q[rs2];
    end
`endif

    assign hazard = haz1 || haz2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            reg_rd_q    <= '0;
            reg_wdata_q <= '0;
            busy_q      <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            reg_rd_q    <= reg_rd_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_write = reg_write_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, round-robin, scoreboard, WAW, x0 and bypass.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 64;
    localparam int AW      = 5;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      wb_valid;
    logic [NUM_REQ*AW-1:0]   wb_rd;
    logic [NUM_REQ*XLEN-1:0] wb_data;
    logic [NUM_REQ-1:0]      wb_ready;
    logic                    issue_valid;
    logic [AW-1:0]           issue_rd;
    logic                    issue_ready;
    logic [AW-1:0]           rs1;
    logic [AW-1:0]           rs2;
    logic                    hazard;
    logic                    reg_write;
    logic [AW-1:0]           reg_rd;
    logic [XLEN-1:0]         reg_wdata;
`ifdef REGFILE_WB_BYPASS_EN
    logic                    byp1_en;
    logic                    byp2_en;
    logic [XLEN-1:0]         byp1_data;
    logic [XLEN-1:0]         byp2_data;
`endif

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .reg_write  (reg_write),
        .reg_rd     (reg_rd),
        .reg_wdata  (reg_wdata)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp1_en    (byp1_en),
        .byp2_en    (byp2_en),
        .byp1_data  (byp1_data),
        .byp2_data  (byp2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int i, input logic v, input logic [AW-1:0] rd,
                          input logic [XLEN-1:0] d);
        wb_valid[i]          = v;
        wb_rd[i*AW +: AW]     = rd;
        wb_data[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        rst_n       = 1'b0;
        wb_valid    = '0;
        wb_rd       = '0;
        wb_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;

        // reset state
        step();
        step();
        chk("rst_reg_write", reg_write, 0);
        chk("rst_reg_rd", reg_rd, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_issue_ready", issue_ready, 1);
        rst_n = 1'b1;
        step();

        // round-robin with all three requesters valid: grants 0,1,2,0,1
        for (int i = 0; i < NUM_REQ; i++) begin
            set_wb(i, 1'b1, AW'(i + 1), 64'h100 + 64'(i));
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", wb_ready, 64'(1 << (k % 3)));
            step();
            chk("rr_reg_write", reg_write, 1);
            chk("rr_reg_rd", reg_rd, 64'((k % 3) + 1));
            chk("rr_reg_wdata", reg_wdata, 64'h100 + 64'(k % 3));
        end
        wb_valid = '0;
        step();
        chk("idle_reg_write", reg_write, 0);
        chk("idle_reg_rd_hold", reg_rd, 2);
        chk("idle_wdata_hold", reg_wdata, 64'h101);

        // reset mid-traffic with busy[5] set and pointer at 2
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        set_wb(1, 1'b1, 5'd2, 64'h101);
        step();
        issue_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_wb(i, 1'b1, AW'(i + 1), 64'h100 + 64'(i));
        end
        rs1 = 5'd5;
        #1;
        chk("pre_rst_hazard", hazard, 1);
        chk("pre_rst_grant", wb_ready, 3'b100);
        chk("pre_rst_reg_write", reg_write, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reg_write", reg_write, 0);
        chk("mid_rst_reg_rd", reg_rd, 0);
        chk("mid_rst_hazard", hazard, 0);
        chk("mid_rst_grant", wb_ready, 3'b001);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", wb_ready, 3'b001);
        step();
        chk("post_rst_reg_rd", reg_rd, 1);
        chk("post_rst_reg_write", reg_write, 1);
        wb_valid = '0;
        rs1      = '0;
        step();

        // scoreboard RAW on x7, cleared by requester 1 writeback
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb_issue_ready", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        rs1         = 5'd7;
        #1;
        chk("sb_hazard_0", hazard, 1);
        step();
        chk("sb_hazard_1", hazard, 1);
        step();
        chk("sb_hazard_2", hazard, 1);
        set_wb(1, 1'b1, 5'd7, 64'hDEAD);
        #1;
        chk("sb_grant", wb_ready, 3'b010);
        step();
        set_wb(1, 1'b0, 5'd7, 64'hDEAD);
        chk("sb_reg_write", reg_write, 1);
        chk("sb_reg_rd", reg_rd, 7);
        chk("sb_reg_wdata", reg_wdata, 64'hDEAD);
        chk("sb_hazard_wr", hazard, 1);
        step();
        chk("sb_reg_write_off", reg_write, 0);
        chk("sb_hazard_clr", hazard, 0);

        // WAW stall on x9, then same-cycle set/clear
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        issue_valid = 1'b0;
        #1;
        chk("waw_issue_ready", issue_ready, 0);
        set_wb(0, 1'b1, 5'd9, 64'h99);
        step();
        set_wb(0, 1'b0, 5'd9, 64'h99);
        chk("waw_wr_reg_rd", reg_rd, 9);
        chk("waw_wr_busy", issue_ready, 0);
        step();
        chk("waw_cleared", issue_ready, 1);
        set_wb(2, 1'b1, 5'd9, 64'h77);
        #1;
        chk("waw_grant2", wb_ready, 3'b100);
        step();
        set_wb(2, 1'b0, 5'd9, 64'h77);
        issue_valid = 1'b1;
        #1;
        chk("sc_reg_write", reg_write, 1);
        chk("sc_issue_ready", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        rs2         = 5'd9;
        #1;
        chk("sc_set_wins", issue_ready, 0);
        chk("sc_hazard", hazard, 1);

        // x0 writeback and issue
        rs1 = '0;
        rs2 = '0;
        set_wb(2, 1'b1, 5'd0, 64'hFFFF);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("x0_grant", wb_ready, 3'b100);
        chk("x0_issue_ready", issue_ready, 1);
        step();
        set_wb(2, 1'b0, 5'd0, 64'hFFFF);
        issue_valid = 1'b0;
        #1;
        chk("x0_reg_write", reg_write, 0);
        chk("x0_issue_ready_after", issue_ready, 1);
        chk("x0_hazard", hazard, 0);
        issue_rd = 5'd9;
        #1;
        chk("x0_busy9_kept", issue_ready, 0);

`ifdef REGFILE_WB_BYPASS_EN
        // bypass of x4 from the registered write port
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        step();
        issue_valid = 1'b0;
        rs2         = 5'd4;
        #1;
        chk("byp_pre_hazard", hazard, 1);
        chk("byp_pre_en", byp2_en, 0);
        set_wb(0, 1'b1, 5'd4, 64'h1234);
        step();
        set_wb(0, 1'b0, 5'd4, 64'h1234);
        #1;
        chk("byp2_en", byp2_en, 1);
        chk("byp2_data", byp2_data, 64'h1234);
        chk("byp_hazard", hazard, 0);
        chk("byp1_en", byp1_en, 0);
        chk("byp1_data", byp1_data, 0);
        step();
        chk("byp_post_en", byp2_en, 0);
        chk("byp_post_hazard", hazard, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
